// File: rtl/writeback_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency results,
// the merged write toward the register file and the pending-write mask.
interface writeback_arbiter_if;
    logic        PipeRegWrite;
    logic [4:0]  PipeWriteRegister;
    logic [31:0] PipeWriteData;
    logic        PipeStall;
    logic        LongValid;
    logic [4:0]  LongWriteRegister;
    logic [31:0] LongWriteData;
    logic        LongReady;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] Pending;

    modport master (
        output PipeRegWrite, PipeWriteRegister, PipeWriteData,
        output LongValid, LongWriteRegister, LongWriteData,
        input  PipeStall, LongReady, RegWrite, WriteRegister, WriteData, Pending
    );

    modport slave (
        input  PipeRegWrite, PipeWriteRegister, PipeWriteData,
        input  LongValid, LongWriteRegister, LongWriteData,
        output PipeStall, LongReady, RegWrite, WriteRegister, WriteData, Pending
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback (priority) with buffered long-latency results onto
// the single register-file write port, with a starvation guard for the buffer.
//
// state  | meaning
// NORMAL | pipeline has priority; count consecutive pipe wins over a non-empty buffer
// DRAIN  | one-cycle pipeline stall so the buffer head gets the write port
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    writeback_arbiter_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic {NORMAL, DRAIN} stateType;

    stateType          state;
    logic [STV_W-1:0]  starveCnt;
    logic [4:0]        fifoReg  [DEPTH];
    logic [31:0]       fifoData [DEPTH];
    logic [DEPTH-1:0]  entryValid;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              regWriteQ;
    logic [4:0]        writeRegQ;
    logic [31:0]       writeDataQ;
    logic              srcLong;
    logic              pipeEff;
    logic              takePipe;
    logic              bufEmpty;
    logic              pop;
    logic              push;
    logic [31:0]       pendingMask;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign pipeEff       = bus.PipeRegWrite && (bus.PipeWriteRegister != 5'd0);
    assign bus.PipeStall = (state == DRAIN);
    assign takePipe      = pipeEff && !bus.PipeStall;
    assign bufEmpty      = (count == '0);
    assign pop           = !takePipe && !bufEmpty;
    assign bus.LongReady = (count < FULL_CNT);
    // Register-0 transfers complete the handshake but are never stored.
    assign push          = bus.LongValid && bus.LongReady && (bus.LongWriteRegister != 5'd0);

    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i]) pendingMask[fifoReg[i]] = 1'b1;
        end
        if (regWriteQ && srcLong) pendingMask[writeRegQ] = 1'b1;
        pendingMask[0] = 1'b0;
    end

    assign bus.Pending       = pendingMask;
    assign bus.RegWrite      = regWriteQ;
    assign bus.WriteRegister = writeRegQ;
    assign bus.WriteData     = writeDataQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifoReg[i]  <= '0;
                fifoData[i] <= '0;
            end
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
            srcLong    <= 1'b0;
        end else begin
            if (pop) begin
                entryValid[rdPtr] <= 1'b0;
                rdPtr             <= nextPtr(rdPtr);
            end
            if (push) begin
                fifoReg[wrPtr]    <= bus.LongWriteRegister;
                fifoData[wrPtr]   <= bus.LongWriteData;
                entryValid[wrPtr] <= 1'b1;
                wrPtr             <= nextPtr(wrPtr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (takePipe) begin
                regWriteQ  <= 1'b1;
                writeRegQ  <= bus.PipeWriteRegister;
                writeDataQ <= bus.PipeWriteData;
                srcLong    <= 1'b0;
            end else if (pop) begin
                regWriteQ  <= 1'b1;
                writeRegQ  <= fifoReg[rdPtr];
                writeDataQ <= fifoData[rdPtr];
                srcLong    <= 1'b1;
            end else begin
                regWriteQ  <= 1'b0;
                srcLong    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= NORMAL;
            starveCnt <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (pop || bufEmpty) begin
                        starveCnt <= '0;
                    end else if (takePipe) begin
                        if (starveCnt == STARVE_MAX - STV_W'(1)) state <= DRAIN;
                        starveCnt <= starveCnt + STV_W'(1);
                    end
                end
                DRAIN: begin
                    state     <= NORMAL;
                    starveCnt <= '0;
                end
                default: begin
                    state     <= NORMAL;
                    starveCnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model predicts
// every register-file write, stall, ready and pending mask cycle by cycle.
module tb_writeback_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wrType;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_arbiter_if bus();

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    wrType      mq[$];
    wrType      sbQ[$];
    int         mCnt;
    bit         mDrain;
    bit         mOutLong;
    bit         mOutValid;
    logic [4:0] mOutReg;

    logic [31:0] rf [32];
    bit          watchR56;
    bit          seenR56;

    // Register file fed by the DUT's write port; commits on the edge after the output appears.
    always @(posedge clk) begin
        if (bus.RegWrite) begin
            rf[bus.WriteRegister] <= bus.WriteData;
            if (watchR56 && (bus.WriteRegister == 5'd5 || bus.WriteRegister == 5'd6)) seenR56 <= 1'b1;
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] modelPending();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        if (mOutValid && mOutLong) m[mOutReg] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic resetModel();
        mq.delete();
        sbQ.delete();
        mCnt      = 0;
        mDrain    = 0;
        mOutLong  = 0;
        mOutValid = 0;
        mOutReg   = '0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance the model,
    // then check the registered write one step after the posedge.
    task automatic step(input bit pv, input logic [4:0] pr, input logic [31:0] pd,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                        output bit pipeTaken, output bit longTaken);
        bit    expReady;
        bit    pipeEff;
        bit    popNow;
        bit    expWrite;
        wrType ent;
        int    sz;
        bus.PipeRegWrite      = pv;
        bus.PipeWriteRegister = pr;
        bus.PipeWriteData     = pd;
        bus.LongValid         = lv;
        bus.LongWriteRegister = lr;
        bus.LongWriteData     = ld;
        #1;
        sz       = mq.size();
        expReady = (sz < DEPTH);
        pipeEff  = pv && (pr != 5'd0);
        checkValue("PipeStall", {31'd0, bus.PipeStall}, {31'd0, mDrain});
        checkValue("LongReady", {31'd0, bus.LongReady}, {31'd0, expReady});
        checkValue("Pending", bus.Pending, modelPending());
        if (pipeEff) checkValue("hazardPendingOnPipeDest", {31'd0, bus.Pending[pr]}, 32'd0);

        pipeTaken = pipeEff && !mDrain;
        longTaken = lv && expReady;
        popNow    = !pipeTaken && (sz > 0);

        if (mDrain) begin
            mDrain = 0;
            mCnt   = 0;
        end else if (popNow || sz == 0) begin
            mCnt = 0;
        end else if (pipeTaken) begin
            mCnt++;
            if (mCnt == STARVE_LIMIT) mDrain = 1;
        end

        expWrite = 1;
        if (pipeTaken) begin
            ent.r = pr;
            ent.d = pd;
            sbQ.push_back(ent);
            mOutLong = 0;
            mOutReg  = pr;
        end else if (popNow) begin
            ent = mq.pop_front();
            sbQ.push_back(ent);
            mOutLong = 1;
            mOutReg  = ent.r;
        end else begin
            expWrite = 0;
        end
        mOutValid = expWrite;
        if (longTaken && lr != 5'd0) begin
            ent.r = lr;
            ent.d = ld;
            mq.push_back(ent);
        end

        @(posedge clk);
        #1;
        checkValue("RegWrite", {31'd0, bus.RegWrite}, {31'd0, expWrite});
        if (bus.RegWrite) begin
            if (sbQ.size() == 0) begin
                checkValue("scoreboardNotEmpty", 32'(sbQ.size()), 32'd1);
            end else begin
                ent = sbQ.pop_front();
                checkValue("WriteRegister", {27'd0, bus.WriteRegister}, {27'd0, ent.r});
                checkValue("WriteData", bus.WriteData, ent.d);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit pt, lt;
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, pt, lt);
    endtask

    initial begin
        bit          pt, lt;
        bit          sawBackpressure;
        int          li;
        int          pipeIdx;
        int          stallSeen;
        logic [4:0]  lReg  [4];
        logic [31:0] lData [4];

        rst = 1'b1;
        watchR56 = 0;
        bus.PipeRegWrite      = 1'b0;
        bus.PipeWriteRegister = '0;
        bus.PipeWriteData     = '0;
        bus.LongValid         = 1'b0;
        bus.LongWriteRegister = '0;
        bus.LongWriteData     = '0;
        resetModel();
        #1;
        checkValue("resetRegWrite", {31'd0, bus.RegWrite}, 32'd0);
        checkValue("resetWriteRegister", {27'd0, bus.WriteRegister}, 32'd0);
        checkValue("resetWriteData", bus.WriteData, 32'd0);
        checkValue("resetPending", bus.Pending, 32'd0);
        checkValue("resetLongReady", {31'd0, bus.LongReady}, 32'd1);
        checkValue("resetPipeStall", {31'd0, bus.PipeStall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pipe only
        step(1, 5'd3, 32'h12345678, 0, 5'd0, 32'd0, pt, lt);
        checkValue("pipeOnlyTaken", {31'd0, pt}, 32'd1);
        idle(1);
        checkValue("regfileR3", rf[3], 32'h12345678);

        // Long only, in-order drain
        step(0, 5'd0, 32'd0, 1, 5'd8, 32'h8, pt, lt);
        checkValue("pendingR8AfterAccept", {31'd0, bus.Pending[8]}, 32'd1);
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h9, pt, lt);
        checkValue("pendingR9AfterAccept", {31'd0, bus.Pending[9]}, 32'd1);
        idle(3);
        checkValue("pendingClearedAfterDrain", bus.Pending, 32'd0);

        // Full buffer and backpressure while the pipe writes every cycle
        lReg[0] = 5'd10; lData[0] = 32'hA;
        lReg[1] = 5'd11; lData[1] = 32'hB;
        lReg[2] = 5'd13; lData[2] = 32'hD;
        lReg[3] = 5'd0;  lData[3] = 32'h0;
        li = 0;
        pipeIdx = 0;
        sawBackpressure = 0;
        for (int c = 0; c < 12; c++) begin
            step(1, 5'(1 + pipeIdx % 4), 32'h100 + 32'(pipeIdx), li < 3, lReg[li], lData[li], pt, lt);
            if (li < 3 && !lt) sawBackpressure = 1;
            if (lt && li < 3) li++;
            if (pt) pipeIdx++;
        end
        idle(4);
        checkValue("backpressureSeen", {31'd0, sawBackpressure}, 32'd1);
        checkValue("allLongAccepted", 32'(li), 32'd3);
        checkValue("scoreboardDrained", 32'(sbQ.size()), 32'd0);

        // Starvation: r12 buffered while the pipe wins four times in a row
        step(1, 5'd7, 32'h7, 1, 5'd12, 32'hC, pt, lt);
        checkValue("starveLongAccepted", {31'd0, lt}, 32'd1);
        stallSeen = 0;
        for (int r = 1; r <= 4; r++) begin
            step(1, 5'(r), 32'(r), 0, 5'd0, 32'd0, pt, lt);
            checkValue("starvePipeWin", {31'd0, pt}, 32'd1);
        end
        if (bus.PipeStall) stallSeen++;
        step(1, 5'd5, 32'h55, 0, 5'd0, 32'd0, pt, lt);
        checkValue("drainPipeHeld", {31'd0, pt}, 32'd0);
        checkValue("drainOutputReg", {27'd0, bus.WriteRegister}, 32'd12);
        checkValue("drainOutputData", bus.WriteData, 32'hC);
        if (bus.PipeStall) stallSeen++;
        step(1, 5'd5, 32'h55, 0, 5'd0, 32'd0, pt, lt);
        checkValue("heldPipeTaken", {31'd0, pt}, 32'd1);
        checkValue("stallCycles", 32'(stallSeen), 32'd1);
        idle(1);

        // Register-0 filtering on both sources
        step(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hEEEEEEEE, pt, lt);
        checkValue("r0LongAccepted", {31'd0, lt}, 32'd1);
        checkValue("r0NoWrite", {31'd0, bus.RegWrite}, 32'd0);
        checkValue("r0NothingPending", bus.Pending, 32'd0);
        checkValue("r0LongReadyAfter", {31'd0, bus.LongReady}, 32'd1);

        // Asynchronous reset with two buffered results in flight
        step(1, 5'd1, 32'h11, 1, 5'd5, 32'hAAAA0005, pt, lt);
        step(1, 5'd2, 32'h22, 1, 5'd6, 32'hAAAA0006, pt, lt);
        checkValue("bufferFullBeforeReset", {31'd0, bus.LongReady}, 32'd0);
        bus.PipeRegWrite = 1'b0;
        bus.LongValid    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkValue("asyncResetRegWrite", {31'd0, bus.RegWrite}, 32'd0);
        checkValue("asyncResetPending", bus.Pending, 32'd0);
        checkValue("asyncResetLongReady", {31'd0, bus.LongReady}, 32'd1);
        checkValue("asyncResetPipeStall", {31'd0, bus.PipeStall}, 32'd0);
        resetModel();
        watchR56 = 1;
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        checkValue("discardedR5R6", {31'd0, seenR56}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the register-file write port. Drives RegWrite, WriteRegister and WriteData into the 32x32 register file.
- Merges two write sources:
  - the in-order pipeline writeback, which is single-cycle and has priority;
  - a long-latency result source (multiply/divide, cache-miss load), buffered in a small FIFO.
- Publishes a 32-bit pending-write mask so the hazard unit can stall RAW/WAW on registers with buffered results.

Parameters:
- DEPTH, 2, number of long-result buffer entries (1..4).
- STARVE_LIMIT, 4, number of consecutive pipeline wins while the buffer is non-empty before the pipeline is stalled for one drain cycle.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- PipeRegWrite  input  1  pipeline writeback request.
- PipeWriteRegister  input  5  pipeline destination register.
- PipeWriteData  input  32  pipeline result.
- PipeStall  output  1  combinational; while 1, the pipeline request is not taken and must be held unchanged.
- LongValid  input  1  long-latency result valid.
- LongWriteRegister  input  5  long-latency destination register.
- LongWriteData  input  32  long-latency result.
- LongReady  output  1  combinational; equals (count < DEPTH); the transfer occurs on LongValid && LongReady.
- RegWrite  output  1  registered; to the register file.
- WriteRegister  output  5  registered; to the register file.
- WriteData  output  32  registered; to the register file.
- Pending  output  32  combinational; bit r = 1 if any valid buffer entry, or the output stage holding a long-sourced write, targets r; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - Buffer empty (count=0, pointers 0), starve counter 0, output-stage source flag cleared.
  - Hence LongReady=1, Pending=0, PipeStall=0.
  - In-flight buffered writes are discarded.
- Pipeline request is effective when PipeRegWrite=1 && PipeWriteRegister!=0. Requests targeting register 0 are ignored: no write, no stall effect.
- Per-cycle output-register selection, at posedge:
  1. Pipeline request effective && PipeStall=0: load the pipe fields, RegWrite=1, src=PIPE.
  2. Otherwise, if count>0: pop the FIFO head into the output, RegWrite=1, src=LONG.
  3. Otherwise: RegWrite=0; WriteRegister and WriteData hold their previous values.
- Latency: a source value appears on the output one cycle after acceptance. The register file commits it on the following edge.
- Long push:
  - On LongValid && LongReady, the entry is appended at the tail.
  - If LongWriteRegister==0, the transfer is accepted and dropped (not stored).
  - LongReady depends on count only: no push when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle with count<DEPTH: count is unchanged, and the FIFO order is preserved.
- FIFO: circular buffer; pointers wrap modulo DEPTH. Entries pop strictly in order.
- Starvation FSM, two states:
  - NORMAL: the counter increments on each cycle where selection rule 1 fires while count>0. It resets to 0 whenever a pop occurs or count==0. When the counter reaches STARVE_LIMIT, go to DRAIN.
  - DRAIN: PipeStall=1 for exactly one cycle. The head is popped (rule 2), the counter clears, and the FSM returns to NORMAL.
  - PipeStall is never asserted in NORMAL.
- Pending:
  - Recomputed combinationally from the valid entries plus the output stage when src=LONG && RegWrite=1.
  - Duplicate destinations are legal; a bit stays 1 until the last matching write leaves the output stage.
- Ordering contract: the pipeline must not present a write to r while Pending[r]=1. The hazard unit guarantees this. The bench flags a violation as an error; the block does not correct it.
- No arithmetic beyond the count and pointers. The count is wide enough for the value DEPTH, and no overflow is possible given LongReady.

Test Plan:
- Reset mid-operation: fill buffer with r5/0xAAAA0005 and r6/0xAAAA0006, assert rst asynchronously between edges -> immediately RegWrite=0, Pending=0, LongReady=1; after release the register file never receives r5/r6.
- Pipe only: PipeRegWrite=1, r3, 0x12345678 -> next cycle RegWrite=1, WriteRegister=3, WriteData=0x12345678; Pending stays 0; register file reads 0x12345678 afterwards.
- Long only, in-order drain: push r8/0x8, then r9/0x9 on consecutive cycles with the pipe idle -> RegWrite outputs r8 then r9 on consecutive cycles; Pending[8] and Pending[9] set on acceptance, cleared one cycle after their respective outputs.
- Full and backpressure: push r10 and r11 while the pipe writes every cycle (DEPTH=2) -> LongReady=0; a third LongValid is held until a pop occurs; no entry is lost or duplicated.
- Starvation: buffer holds r12/0xC, pipe writes r1..r4 on consecutive cycles -> after 4 pipe wins PipeStall=1 for one cycle, the output carries r12/0xC, and the held pipe request is taken the next cycle.
- Register-0 filtering: pipe r0/0xFFFFFFFF and long r0/0xEEEEEEEE in the same cycle -> RegWrite stays 0, count stays 0, Pending[0]=0, and the long transfer is accepted (LongReady=1).
